// File: rtl/inst_mem_loader_if.sv
// rtl/inst_mem_loader_if.sv - byte stream in / instruction memory write out bundle
// Purpose: groups the loader's byte-stream handshake and its memory write port.
// Signals:
//   in_valid, in_data  : byte stream from the host receiver
//   in_ready           : loader accepts in_data this cycle
//   mem_we             : one-cycle instruction memory write strobe
//   mem_waddr          : word-aligned byte address of the write
//   mem_wdata          : assembled little-endian instruction word
// Modports: master = host/stream side, slave = loader.
interface inst_mem_loader_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - assembles a byte stream into instruction memory word writes
// Purpose: receives a 16-bit little-endian length header followed by len
// little-endian 32-bit instructions and writes them to BASE_ADDR + 4*k,
// holding the CPU while a session is active or has failed.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load_start  : one-cycle pulse starting a session (IDLE/DONE/ERR only)
//   bus         : byte stream in and memory write port (slave modport)
//   cpu_hold    : CPU must not fetch
//   done / err  : session completed / header exceeded DEPTH (sticky)
//   word_count  : words written in the current session
module inst_mem_loader #(
  parameter int                DEPTH     = 401,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  inst_mem_loader_if.slave   bus,
  output logic               cpu_hold,
  output logic               done,
  output logic               err,
  output logic [15:0]        word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       count_q, count_d;

  logic        in_ready;
  logic        mem_we;
  logic        xfer;
  logic [15:0] len_new;

  assign xfer    = in_ready & bus.in_valid;
  assign len_new = {bus.in_data, len_q[7:0]};

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    asm_d    = asm_q;
    wdata_d  = wdata_q;
    waddr_d  = waddr_q;
    count_d  = count_q;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    cpu_hold = 1'b0;
    done     = 1'b0;
    err      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LEN_LO;
          count_d = '0;
        end
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (xfer) begin
          len_d[7:0] = bus.in_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (xfer) begin
          len_d = len_new;
          idx_d = '0;
          if ({16'd0, len_new} > 32'(DEPTH)) state_d = S_ERR;
          else if (len_new == 16'd0)         state_d = S_DONE;
          else                               state_d = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (xfer) begin
          asm_d[{idx_q, 3'b000} +: 8] = bus.in_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Latch the word and address now so they are stable during the
            // write cycle and hold afterwards while the next word assembles.
            wdata_d = {bus.in_data, asm_q[23:0]};
            waddr_d = BASE_ADDR + ADDR_W'({count_q, 2'b00});
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        mem_we   = 1'b1;
        cpu_hold = 1'b1;
        count_d  = count_q + 16'd1;
        idx_d    = '0;
        state_d  = (count_d == len_q) ? S_DONE : S_DATA;
      end
      S_DONE: begin
        done = 1'b1;
        if (load_start) begin
          state_d = S_LEN_LO;
          count_d = '0;
        end
      end
      S_ERR: begin
        cpu_hold = 1'b1;
        err      = 1'b1;
        if (load_start) begin
          state_d = S_LEN_LO;
          count_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we;
  assign bus.mem_waddr = waddr_q;
  assign bus.mem_wdata = wdata_q;
  assign word_count    = count_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - directed self-checking bench for inst_mem_loader
module tb_inst_mem_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        cpu_hold, done, err;
  logic [15:0] word_count;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];

  inst_mem_loader_if #(.ADDR_W(32)) bus ();

  inst_mem_loader #(.DEPTH(401), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (bus.mem_we === 1'b1) begin
      wa.push_back(bus.mem_waddr);
      wd.push_back(bus.mem_wdata);
      wc.push_back(cyc);
    end
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      compared++;
      mismatched++;
      $display("FAIL send_byte_timeout: in_ready=%b required 1 for byte %h", bus.in_ready, b);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_stream(input logic [7:0] s[], input int gap);
    foreach (s[i]) send_byte(s[i], gap);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if ({bus.in_ready, bus.mem_we, cpu_hold, done, err} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_flags: got %b required 00000", {bus.in_ready, bus.mem_we, cpu_hold, done, err});
    end
    compared++;
    if (bus.mem_waddr !== 32'h0 || bus.mem_wdata !== 32'h0 || word_count !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_regs: addr=%h data=%h cnt=%0d required 0/0/0", bus.mem_waddr, bus.mem_wdata, word_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_two_words(input string name, input int gap);
    logic [7:0] s[] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'hB3, 8'h01, 8'h00, 8'h00};
    clear_log();
    pulse_load();
    compared++;
    if (cpu_hold !== 1'b1 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_hold: cpu_hold=%b done=%b required 1/0", name, cpu_hold, done);
    end
    send_stream(s, gap);
    repeat (2) @(negedge clk);
    compared++;
    if (wa.size() != 2) begin
      mismatched++;
      $display("FAIL %s_nwrites: got %0d required 2", name, wa.size());
    end else begin
      compared++;
      if (wa[0] !== 32'h0 || wd[0] !== 32'h00500013) begin
        mismatched++;
        $display("FAIL %s_write0: got %h/%h required 00000000/00500013", name, wa[0], wd[0]);
      end
      compared++;
      if (wa[1] !== 32'h4 || wd[1] !== 32'h000001B3) begin
        mismatched++;
        $display("FAIL %s_write1: got %h/%h required 00000004/000001b3", name, wa[1], wd[1]);
      end
      if (gap == 0) begin
        compared++;
        if (wc[1] - wc[0] != 5) begin
          mismatched++;
          $display("FAIL %s_spacing: got %0d cycles required 5", name, wc[1] - wc[0]);
        end
      end
    end
    compared++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || word_count !== 16'd2 || bus.in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_end: done=%b hold=%b cnt=%0d rdy=%b required 1/0/2/0", name, done, cpu_hold, word_count, bus.in_ready);
    end
  endtask

  task automatic test_basic();
    run_two_words("basic", 0);
  endtask

  task automatic test_gaps();
    run_two_words("gaps", 3);
  endtask

  task automatic test_err();
    logic [7:0] h[] = '{8'h92, 8'h01};
    logic [7:0] s[] = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    clear_log();
    pulse_load();
    send_stream(h, 0);
    repeat (3) @(negedge clk);
    compared++;
    if (err !== 1'b1 || cpu_hold !== 1'b1 || bus.in_ready !== 1'b0 || done !== 1'b0 || wa.size() != 0) begin
      mismatched++;
      $display("FAIL err_state: err=%b hold=%b rdy=%b done=%b nw=%0d required 1/1/0/0/0", err, cpu_hold, bus.in_ready, done, wa.size());
    end
    pulse_load();
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("FAIL err_clear: err=%b required 0", err);
    end
    send_stream(s, 0);
    repeat (2) @(negedge clk);
    compared++;
    if (wa.size() != 1 || wa[0] !== 32'h0 || wd[0] !== 32'h12345678) begin
      mismatched++;
      $display("FAIL err_recover_write: nw=%0d required 1 with 00000000/12345678", wa.size());
    end
    compared++;
    if (done !== 1'b1 || err !== 1'b0 || word_count !== 16'd1) begin
      mismatched++;
      $display("FAIL err_recover_end: done=%b err=%b cnt=%0d required 1/0/1", done, err, word_count);
    end
  endtask

  task automatic test_zero_len();
    logic [7:0] h[] = '{8'h00, 8'h00};
    clear_log();
    pulse_load();
    send_stream(h, 0);
    compared++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || word_count !== 16'd0 || wa.size() != 0) begin
      mismatched++;
      $display("FAIL zero_len: done=%b hold=%b cnt=%0d nw=%0d required 1/0/0/0", done, cpu_hold, word_count, wa.size());
    end
  endtask

  task automatic test_rst_mid();
    logic [7:0] a[] = '{8'h02, 8'h00, 8'h13, 8'h00};
    logic [7:0] b[] = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    clear_log();
    pulse_load();
    send_stream(a, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    compared++;
    if ({bus.in_ready, bus.mem_we, cpu_hold, done, err} !== 5'b0 || bus.mem_waddr !== 32'h0 ||
        bus.mem_wdata !== 32'h0 || word_count !== 16'h0) begin
      mismatched++;
      $display("FAIL rst_mid_outputs: flags=%b addr=%h data=%h cnt=%0d required all 0",
               {bus.in_ready, bus.mem_we, cpu_hold, done, err}, bus.mem_waddr, bus.mem_wdata, word_count);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (wa.size() != 0) begin
      mismatched++;
      $display("FAIL rst_mid_nowrite: nw=%0d required 0", wa.size());
    end
    pulse_load();
    send_stream(b, 0);
    repeat (2) @(negedge clk);
    compared++;
    if (wa.size() != 1 || wa[0] !== 32'h0 || wd[0] !== 32'hDEADBEEF || done !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_mid_fresh: nw=%0d done=%b required 1 write 00000000/deadbeef, done 1", wa.size(), done);
    end
  endtask

  task automatic test_load_ignored();
    logic [7:0] h[] = '{8'h02, 8'h00, 8'h13};
    logic [7:0] t[] = '{8'h00, 8'h50, 8'h00, 8'hB3, 8'h01, 8'h00, 8'h00};
    clear_log();
    pulse_load();
    send_stream(h, 0);
    pulse_load();
    send_stream(t, 0);
    repeat (2) @(negedge clk);
    compared++;
    if (wa.size() != 2 || wd[0] !== 32'h00500013 || wd[1] !== 32'h000001B3 || wa[1] !== 32'h4) begin
      mismatched++;
      $display("FAIL load_ignored_writes: nw=%0d required 2 writes 00500013, 000001b3@4", wa.size());
    end
    compared++;
    if (done !== 1'b1 || word_count !== 16'd2) begin
      mismatched++;
      $display("FAIL load_ignored_end: done=%b cnt=%0d required 1/2", done, word_count);
    end
  endtask

  task automatic test_boundary();
    logic [15:0] k;
    int bad;
    clear_log();
    pulse_load();
    send_byte(8'h91, 0);
    send_byte(8'h01, 0);
    for (int i = 0; i < 401; i++) begin
      k = 16'(i);
      send_byte(k[7:0], 0);
      send_byte(k[15:8], 0);
      send_byte(8'h00, 0);
      send_byte(8'hA5, 0);
    end
    repeat (2) @(negedge clk);
    compared++;
    if (wa.size() != 401 || done !== 1'b1 || word_count !== 16'd401 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL boundary_end: nw=%0d done=%b cnt=%0d err=%b required 401/1/401/0", wa.size(), done, word_count, err);
    end else begin
      compared++;
      if (wa[400] !== 32'h640) begin
        mismatched++;
        $display("FAIL boundary_last_addr: got %h required 00000640", wa[400]);
      end
      bad = 0;
      for (int i = 0; i < 401; i++)
        if (wa[i] !== 32'(4 * i) || wd[i] !== (32'hA5000000 | 32'(i))) bad++;
      compared++;
      if (bad != 0) begin
        mismatched++;
        $display("FAIL boundary_words: %0d bad words required 0", bad);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_gaps();
    test_err();
    test_zero_len();
    test_rst_mid();
    test_load_ignored();
    test_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
